// File: rtl/i2s_tx_pkg.sv
// Shared definitions for the I2S transmitter: register offsets (address bits
// [3:2]), CTRL/STATUS bit positions, the stereo sample type and the byte-strobe
// merge helper used by the register file.
package i2s_tx_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_DIV    = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_TXDATA = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_IE      = 2;
    localparam int CTRL_THR_LSB = 8;
    localparam int CTRL_THR_MSB = 12;

    localparam int ST_FULL      = 8;
    localparam int ST_EMPTY     = 9;
    localparam int ST_UNDERRUN  = 16;
    localparam int ST_OVERFLOW  = 17;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } sample_t;

    // Replace each byte of old_v whose strobe is set with the matching byte of wd.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] wd,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// Synchronous stereo-sample FIFO.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, data_i    write request and sample; accepted when not full or
//                     when a pop happens in the same cycle
//   pop_i, data_o     read request (ignored when empty) and head sample
//   flush_i           empties the FIFO; wins over same-cycle push/pop
//   level_o, full_o, empty_o  occupancy
module i2s_tx_fifo
    import i2s_tx_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  sample_t       data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output sample_t       data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    sample_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A full FIFO can still take a push when the head leaves in the same cycle;
    // the write lands in the slot being vacated.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter slave on the audio side of the bridge.
// Ports:
//   clk_i, rst_i                 audio clock, synchronous active-high reset
//   mem_valid_i .. mem_wstrb_i   native bus request (wstrb == 0 is a read)
//   mem_rdata_o, mem_ready_o     one-cycle completion pulse with read data
//   i2s_sclk_o, i2s_lrck_o, i2s_sdata_o  I2S bit clock, word select, data
//   irq_o                        FIFO low-water interrupt (level)
// Registers: CTRL(EN, FLUSH, IE, THRESH), DIV, STATUS, TXDATA.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        i2s_sclk_o,
    output logic        i2s_lrck_o,
    output logic        i2s_sdata_o,
    output logic        irq_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             en_q, en_d, ie_q, ie_d;
    logic [4:0]       thresh_q, thresh_d;
    logic [DIV_W-1:0] div_q, div_d, div_act_q, div_act_d, cnt_q, cnt_d;
    logic             sclk_q, sclk_d, lrck_q, lrck_d;
    logic [4:0]       slot_q, slot_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             underrun_q, underrun_d, overflow_q, overflow_d;
    logic             irq_q, irq_d;

    logic             accept, is_write;
    logic             wr_ctrl, wr_div, wr_status, wr_txdata;
    logic [31:0]      ctrl_cur, ctrl_new, status;
    logic             push, pop, flush, tick, fall, load;
    sample_t          fifo_head;
    logic [LW-1:0]    level;
    logic             full, empty;
    logic             unused_bits;

    assign unused_bits = ^{mem_addr_i[31:4], mem_addr_i[1:0], ctrl_new[31:13], ctrl_new[7:3]};

    i2s_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (mem_wdata_i),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (fifo_head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        // Bus decode: a request is taken only while ready is low, so a held
        // valid cannot produce back-to-back completions.
        accept    = mem_valid_i & ~ready_q;
        is_write  = |mem_wstrb_i;
        wr_ctrl   = accept & is_write & (mem_addr_i[3:2] == REG_CTRL);
        wr_div    = accept & is_write & (mem_addr_i[3:2] == REG_DIV);
        wr_status = accept & is_write & (mem_addr_i[3:2] == REG_STATUS);
        wr_txdata = accept & is_write & (mem_addr_i[3:2] == REG_TXDATA);

        ctrl_cur = '0;
        ctrl_cur[CTRL_EN] = en_q;
        ctrl_cur[CTRL_IE] = ie_q;
        ctrl_cur[CTRL_THR_MSB:CTRL_THR_LSB] = thresh_q;
        ctrl_new = apply_strb(ctrl_cur, mem_wdata_i, mem_wstrb_i);

        status = '0;
        status[5:0]         = 6'(level);
        status[ST_FULL]     = full;
        status[ST_EMPTY]    = empty;
        status[ST_UNDERRUN] = underrun_q;
        status[ST_OVERFLOW] = overflow_q;

        // Divider and frame timing; a falling toggle out of slot 0 enters slot 1.
        tick  = en_q && (cnt_q == div_act_q);
        fall  = tick && sclk_q;
        load  = fall && (slot_q == 5'd0);
        pop   = load && !empty;
        push  = wr_txdata;
        flush = wr_ctrl && ctrl_new[CTRL_FLUSH];

        ready_d    = accept;
        rdata_d    = '0;
        en_d       = en_q;
        ie_d       = ie_q;
        thresh_d   = thresh_q;
        div_d      = div_q;
        div_act_d  = div_act_q;
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        lrck_d     = lrck_q;
        slot_d     = slot_q;
        shreg_d    = shreg_q;
        underrun_d = underrun_q;
        overflow_d = overflow_q;

        if (accept && !is_write) begin
            case (mem_addr_i[3:2])
                REG_CTRL:   rdata_d = ctrl_cur;
                REG_DIV:    rdata_d = 32'(div_q);
                REG_STATUS: rdata_d = status;
                default:    rdata_d = '0;
            endcase
        end

        if (wr_ctrl) begin
            en_d     = ctrl_new[CTRL_EN];
            ie_d     = ctrl_new[CTRL_IE];
            thresh_d = ctrl_new[CTRL_THR_MSB:CTRL_THR_LSB];
        end
        if (wr_div) div_d = DIV_W'(apply_strb(32'(div_q), mem_wdata_i, mem_wstrb_i));

        if (!en_q) begin
            // Idle: pins low, frame parked so the first falling toggle enters slot 0.
            cnt_d     = '0;
            div_act_d = div_q;
            sclk_d    = 1'b0;
            lrck_d    = 1'b0;
            slot_d    = 5'd31;
            shreg_d   = '0;
        end else if (tick) begin
            cnt_d     = '0;
            div_act_d = div_q;
            sclk_d    = ~sclk_q;
            if (sclk_q) begin
                slot_d = slot_q + 5'd1;
                lrck_d = slot_d[4];
                if (load) shreg_d = empty ? 32'd0 : fifo_head;
                else      shreg_d = {shreg_q[30:0], 1'b0};
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Sticky flags: a same-cycle set wins over write-1-to-clear.
        if (wr_status && mem_wdata_i[ST_UNDERRUN]) underrun_d = 1'b0;
        if (wr_status && mem_wdata_i[ST_OVERFLOW]) overflow_d = 1'b0;
        if (load && empty) underrun_d = 1'b1;
        if (push && full && !pop && !flush) overflow_d = 1'b1;

        irq_d = ie_q && en_q && (32'(level) < 32'(thresh_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            thresh_q   <= '0;
            div_q      <= '0;
            div_act_q  <= '0;
            cnt_q      <= '0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            slot_q     <= 5'd31;
            shreg_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            thresh_q   <= thresh_d;
            div_q      <= div_d;
            div_act_q  <= div_act_d;
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            lrck_q     <= lrck_d;
            slot_q     <= slot_d;
            shreg_q    <= shreg_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;
    assign i2s_sclk_o  = sclk_q;
    assign i2s_lrck_o  = lrck_q;
    assign i2s_sdata_o = shreg_q[31];
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_DIV    = 32'h4;
    localparam logic [31:0] A_STATUS = 32'h8;
    localparam logic [31:0] A_TXD    = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        i2s_sclk, i2s_lrck, i2s_sdata, irq;

    int n_cmp = 0;
    int n_fail = 0;

    // Receiver-side capture of decoded words.
    logic [15:0] capL[$];
    logic [15:0] capR[$];
    logic        mon_rst = 1'b0;
    logic        sclk_prev = 1'b0, lrck_prev = 1'b0;
    logic [15:0] acc = '0;

    i2s_tx #(.FIFO_DEPTH(16), .DIV_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_valid_i (mem_valid),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_rdata_o (mem_rdata),
        .mem_ready_o (mem_ready),
        .i2s_sclk_o  (i2s_sclk),
        .i2s_lrck_o  (i2s_lrck),
        .i2s_sdata_o (i2s_sdata),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    // An I2S receiver samples SD on SCLK rise; a word ends on the bit where
    // LRCK changes (one-bit delay), so the 16 most recent bits form the word
    // of the channel that was just left.
    always @(negedge clk) begin
        if (mon_rst) begin
            capL.delete();
            capR.delete();
            sclk_prev = 1'b0;
            lrck_prev = 1'b0;
            acc = '0;
        end else begin
            if (i2s_sclk && !sclk_prev) begin
                acc = {acc[14:0], i2s_sdata};
                if (i2s_lrck != lrck_prev) begin
                    if (i2s_lrck) capL.push_back(acc);
                    else          capR.push_back(acc);
                end
                lrck_prev = i2s_lrck;
            end
            sclk_prev = i2s_sclk;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd, output int lat);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wstrb = strb;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mem_ready !== 1'b1 && lat < 8);
        if (mem_ready !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL bus_timeout: no ready after %0d cycles, required within 1", lat);
        end
        rd = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] d; int lat;
        bus_xfer(addr, wd, 4'hF, d, lat);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        int lat;
        bus_xfer(addr, 32'h0, 4'h0, d, lat);
    endtask

    task automatic pulse_mon_rst();
        @(negedge clk); mon_rst = 1'b1;
        @(negedge clk); @(negedge clk); mon_rst = 1'b0;
    endtask

    task automatic prep();
        wr(A_CTRL, 32'h0);
        wr(A_CTRL, 32'h2);
        wr(A_STATUS, 32'h0003_0000);
        pulse_mon_rst();
    endtask

    task automatic wait_words(input int n, input int budget, input string nm);
        int c;
        c = 0;
        while (capR.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (capR.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: got %0d words, required %0d", nm, capR.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; int lat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_ready, i2s_sclk, i2s_lrck, i2s_sdata, irq} !== 5'b0 || mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready/sclk/lrck/sd/irq=%b rdata=%h, required all 0",
                     {mem_ready, i2s_sclk, i2s_lrck, i2s_sdata, irq}, mem_rdata);
        end
        rst = 1'b0;
        bus_xfer(A_STATUS, 32'h0, 4'h0, d, lat);
        n_cmp++;
        if (d !== 32'h0000_0200) begin
            n_fail++; $display("FAIL reset_status: got %h, required 00000200", d);
        end
        n_cmp++;
        if (lat != 1) begin
            n_fail++; $display("FAIL ready_latency: got %0d cycles, required 1", lat);
        end
        @(negedge clk);
        n_cmp++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
            n_fail++; $display("FAIL ready_pulse: ready=%b rdata=%h, required 0 and 0", mem_ready, mem_rdata);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d; int lat;
        bus_xfer(A_DIV, 32'h1234_56AB, 4'b0001, d, lat);
        rd(A_DIV, d);
        n_cmp++;
        if (d !== 32'h0000_00AB) begin
            n_fail++; $display("FAIL div_strobe: got %h, required 000000ab", d);
        end
        bus_xfer(A_CTRL, 32'hFFFF_FFFF, 4'b0010, d, lat);
        rd(A_CTRL, d);
        n_cmp++;
        if (d !== 32'h0000_1F00) begin
            n_fail++; $display("FAIL ctrl_strobe: got %h, required 00001f00", d);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_serial();
        int r1, r2, s1;
        logic sp;
        prep();
        wr(A_DIV, 32'd1);
        wr(A_TXD, 32'hA5A5_3C3C);
        wr(A_CTRL, 32'h1);
        r1 = -1; r2 = -1; s1 = -1;
        sp = i2s_sclk;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (i2s_sclk && !sp) begin
                if (r1 < 0) r1 = n;
                else if (r2 < 0) r2 = n;
            end
            sp = i2s_sclk;
            if (i2s_sdata && s1 < 0) s1 = n;
        end
        n_cmp++;
        if (r1 != 2) begin n_fail++; $display("FAIL first_rise: cycle %0d, required 2", r1); end
        n_cmp++;
        if (r2 - r1 != 4) begin n_fail++; $display("FAIL sclk_period: %0d, required 4", r2 - r1); end
        n_cmp++;
        if (s1 != 8) begin n_fail++; $display("FAIL first_pop: cycle %0d, required 8", s1); end
        wait_words(1, 600, "serial");
        if (capR.size() >= 1) begin
            n_cmp++;
            if (capL[0] !== 16'hA5A5) begin n_fail++; $display("FAIL serial_L: got %h, required a5a5", capL[0]); end
            n_cmp++;
            if (capR[0] !== 16'h3C3C) begin n_fail++; $display("FAIL serial_R: got %h, required 3c3c", capR[0]); end
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int pushed;
        prep();
        pushed = 17;
        for (int i = 0; i < pushed; i++) wr(A_TXD, $urandom);
        rd(A_STATUS, d);
        n_cmp++;
        // 16 held, FULL, OVERFLOW from the 17th push
        if (d !== ((32'(pushed > 16 ? 16 : pushed)) | 32'h100 | 32'h2_0000)) begin
            n_fail++; $display("FAIL overflow_status: got %h, required 00020110", d);
        end
        wr(A_STATUS, 32'h0002_0000);
        rd(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0110) begin
            n_fail++; $display("FAIL overflow_clear: got %h, required 00000110", d);
        end
    endtask

    task automatic test_underrun();
        logic [31:0] d;
        logic seen;
        prep();
        wr(A_DIV, 32'd0);
        wr(A_CTRL, 32'h1);
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            seen = seen | i2s_sdata;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL underrun_sdata: saw %b, required 0", seen); end
        rd(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0001_0200) begin
            n_fail++; $display("FAIL underrun_status: got %h, required 00010200", d);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_irq();
        int t;
        prep();
        wr(A_DIV, 32'd0);
        wr(A_CTRL, 32'h0000_0404);
        for (int i = 0; i < 5; i++) wr(A_TXD, $urandom);
        wr(A_CTRL, 32'h0000_0405);
        t = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (irq) begin t = n; break; end
        end
        // Pops at 4 and 4+64 clocks (DIV=0); irq is registered one cycle later.
        n_cmp++;
        if (t != 69) begin n_fail++; $display("FAIL irq_rise: cycle %0d, required 69", t); end
        wr(A_TXD, $urandom);
        n_cmp++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold: got %b, required 1", irq); end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b, required 0", irq); end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d;
        prep();
        wr(A_DIV, 32'd0);
        for (int i = 0; i < 16; i++) wr(A_TXD, $urandom);
        wr(A_CTRL, 32'h1);
        // First pop lands on the 4th edge after EN; present the push so it is taken there.
        repeat (3) @(negedge clk);
        mem_valid = 1'b1; mem_addr = A_TXD; mem_wdata = 32'h1357_9BDF; mem_wstrb = 4'hF;
        @(negedge clk);
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_ready: got %b, required 1", mem_ready); end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        rd(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0110) begin
            n_fail++; $display("FAIL pushpop_status: got %h, required 00000110", d);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_flush();
        logic [31:0] d;
        logic [31:0] a;
        prep();
        wr(A_DIV, 32'd0);
        a = $urandom;
        wr(A_TXD, a);
        wr(A_TXD, $urandom);
        wr(A_CTRL, 32'h1);
        repeat (10) @(negedge clk);
        wr(A_CTRL, 32'h3);
        rd(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0200) begin
            n_fail++; $display("FAIL flush_status: got %h, required 00000200", d);
        end
        wait_words(1, 400, "flush");
        if (capR.size() >= 1) begin
            n_cmp++;
            if (capL[0] !== a[31:16]) begin n_fail++; $display("FAIL flush_L: got %h, required %h", capL[0], a[31:16]); end
            n_cmp++;
            if (capR[0] !== a[15:0]) begin n_fail++; $display("FAIL flush_R: got %h, required %h", capR[0], a[15:0]); end
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_random_stream();
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int d, n;
        for (int it = 0; it < 3; it++) begin
            prep();
            d = $urandom_range(0, 3);
            n = $urandom_range(3, 8);
            wr(A_DIV, 32'(d));
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                e = $urandom;
                wr(A_TXD, e);
                exp_q.push_back(e);
            end
            wr(A_CTRL, 32'h1);
            wait_words(n, (n + 2) * 64 * (d + 1) + 100, "random");
            for (int i = 0; i < n && i < capR.size(); i++) begin
                e = exp_q[i];
                n_cmp++;
                if (capL[i] !== e[31:16]) begin
                    n_fail++; $display("FAIL random_L[%0d]: got %h, required %h (div %0d)", i, capL[i], e[31:16], d);
                end
                n_cmp++;
                if (capR[i] !== e[15:0]) begin
                    n_fail++; $display("FAIL random_R[%0d]: got %h, required %h (div %0d)", i, capR[i], e[15:0], d);
                end
            end
            wr(A_CTRL, 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        prep();
        wr(A_DIV, 32'd0);
        wr(A_TXD, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        mem_valid = 1'b1; mem_addr = A_CTRL; mem_wdata = 32'h1; mem_wstrb = 4'hF;
        @(negedge clk);
        n_cmp++;
        if ({mem_ready, i2s_sclk, i2s_lrck, i2s_sdata, irq} !== 5'b0 || mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready/sclk/lrck/sd/irq=%b rdata=%h, required all 0",
                     {mem_ready, i2s_sclk, i2s_lrck, i2s_sdata, irq}, mem_rdata);
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        rst = 1'b0;
        rd(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0000_0200) begin n_fail++; $display("FAIL midreset_status: got %h, required 00000200", d); end
        rd(A_CTRL, d);
        n_cmp++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_ctrl: got %h, required 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_serial();
        test_overflow();
        test_underrun();
        test_irq();
        test_push_pop_full();
        test_flush();
        test_random_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio-domain I2S transmitter. It is the slave that terminates the clock-domain-crossed native bus (valid/ready, addr, wdata, wstrb, rdata) coming out of the audio-side bridge port.
- It replaces the tied-off audio slave: the bridge's rdata/ready inputs are driven from this block.
- It holds a register file and a stereo sample FIFO. A serializer drives I2S SCLK/LRCK/SD, all derived from the single audio clock.

Parameters:
- FIFO_DEPTH, 16, number of stereo entries; power of two, minimum 4.
- DIV_W, 8, width of the SCLK divider register.

Ports:
- clk_i  in  1  audio clock (clk_aud domain).
- rst_i  in  1  reset; synchronous, active-high.
- mem_valid_i  in  1  request valid; held high until mem_ready_o.
- mem_addr_i  in  32  byte address; only bits [3:2] are decoded.
- mem_wdata_i  in  32  write data.
- mem_wstrb_i  in  4  byte strobes; zero means a read.
- mem_rdata_o  out  32  read data; valid in the cycle mem_ready_o is high.
- mem_ready_o  out  1  one-cycle completion pulse.
- i2s_sclk_o  out  1  bit clock.
- i2s_lrck_o  out  1  word select; 0 = left, 1 = right.
- i2s_sdata_o  out  1  serial data, MSB first.
- irq_o  out  1  level interrupt, FIFO low-water.

Behaviour:
- Reset: every output is 0. Registers are cleared, the FIFO is empty, slot = 31, the divider count is 0.
- Bus handshake:
  - mem_ready_o pulses exactly one cycle after mem_valid_i is sampled high, and only when ready was low in that sampled cycle. No back-to-back pulse occurs without a fresh valid.
  - No stall condition exists.
  - mem_rdata_o is 0 whenever mem_ready_o is low.
- Register map:
  - [3:2]=0 CTRL: bit0 EN, bit1 FLUSH (write-1 self-clearing, empties the FIFO), bit2 IE, bits[12:8] THRESH.
  - [3:2]=1 DIV: SCLK half-period is DIV+1 clk cycles.
  - [3:2]=2 STATUS: bits[5:0] LEVEL, bit8 FULL, bit9 EMPTY, bit16 UNDERRUN, bit17 OVERFLOW. UNDERRUN and OVERFLOW are sticky and write-1-to-clear.
  - [3:2]=3 TXDATA: a write pushes {L[15:0] = wdata[31:16], R[15:0] = wdata[15:0]}. A read returns 0.
  - Byte strobes apply to CTRL and DIV. A TXDATA push happens on any nonzero wstrb.
- Push rules:
  - A push is accepted if LEVEL < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the data is dropped and OVERFLOW is set. Ready is still given.
  - Simultaneous push and pop leave LEVEL unchanged.
  - FLUSH takes priority over a same-cycle push or pop.
- Divider:
  - While EN=1, the counter counts 0..DIV; at DIV it toggles SCLK and reloads 0.
  - A DIV write takes effect at the next reload.
  - DIV=0 gives SCLK = clk/2.
- Frame:
  - 32 slots, advanced on each SCLK falling toggle; slot wraps 31→0.
  - LRCK = 0 for slots 0..15 and 1 for slots 16..31. LRCK and SDATA change only on falling toggles.
  - On entering slot 1: pop the FIFO and load the 32-bit shift register. If the FIFO is empty, load 0 and set UNDERRUN.
  - On every other falling toggle the register shifts left. SDATA = shreg[31].
  - Result: L MSB in slot 1, R MSB in slot 17, R LSB in slot 0 of the next frame (standard one-bit I2S delay).
- EN 1→0: SCLK, LRCK and SDATA are forced to 0 the next cycle. The counter goes to 0, slot to 31, shreg to 0. FIFO contents are kept.
- EN 0→1: the first SCLK rise comes DIV+1 cycles later; the first pop comes 4·(DIV+1) cycles after EN.
- irq_o = IE & EN & (LEVEL < THRESH), registered (one-cycle delay).
- Reset mid-frame aborts immediately to reset values. A pending bus request gets no ready.

Decomposition:
- Package i2s_tx_pkg holds:
  - register offset constants;
  - CTRL and STATUS bit-position constants;
  - a packed struct for the stereo sample {l, r}.
- Sub-module i2s_tx_fifo: a synchronous FIFO with push, pop, flush, level, full and empty.

Test Plan:
- Reset, then read STATUS → rdata = 0x0000_0200 (EMPTY); all I2S pins 0; ready arrives exactly 1 cycle after valid.
- DIV=1, push 0xA5A5_3C3C, EN=1:
  - SCLK period is 4 clk;
  - first pop occurs at cycle 8 after EN;
  - captured L = 0xA5A5 and R = 0x3C3C.
- Push 17 entries with DEPTH=16 and EN=0 → LEVEL=16, FULL=1, OVERFLOW=1. Write 0x20000 to STATUS → OVERFLOW clears.
- EN=1 with an empty FIFO → SDATA stays 0 and UNDERRUN=1 after the first slot-1 entry.
- THRESH=4, IE=1, EN=1, 5 entries pushed → irq_o rises after the second pop (LEVEL=3). A further push clears irq_o.
- Push and pop in the same cycle at LEVEL=16 → push accepted, LEVEL stays 16, no OVERFLOW.
- FLUSH mid-frame → LEVEL=0; the current shreg finishes transmitting.
